register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Register file for the 16-bit datapath: holds PC, R1, R2, TR, R, AC and AR.
- Drives these registers directly onto the bus-B source multiplexer inputs, which sit immediately downstream.
- Loads from the ALU result bus (bus C) under per-register write enables, and supports in-place increment/decrement for pointer and loop-counter registers.
- Produces registered zero flags for AC and R, consumed by the control sequencer for branching.

Parameters:
- WIDTH, 16, width of every register and of BUS_C.
- PC_RESET, 16'h0000, value loaded into PC on reset.

Ports:
- CLOCK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- WRITE_EN  input  7  load-from-BUS_C enables; bit0 PC, bit1 R1, bit2 R2, bit3 TR, bit4 R, bit5 AC, bit6 AR.
- INC_PC  input  1  increment PC by 1.
- INC_AR  input  1  increment AR by 1.
- INC_R1  input  1  increment R1 by 1.
- DEC_R  input  1  decrement R by 1.
- CLR_AC  input  1  clear AC to 0.
- BUS_C  input  WIDTH  ALU result bus, the data source for loads.
- PC, R1, R2, TR, R, AC, AR  output  WIDTH each  current register contents, driven straight from flops.
- Z_AC  output  1  registered flag, 1 when AC holds 0.
- Z_R  output  1  registered flag, 1 when R holds 0.

Behaviour:
- Synchronous reset: on a rising edge with RESET=1, PC=PC_RESET and all other registers = 0.
  - Z_AC=1 and Z_R=1 after reset.
  - RESET overrides every other input, including mid-operation (e.g. during a load or increment burst).
- Outputs are flop outputs only; no combinational path from any input to any output.
- Latency: an operation requested in cycle N is visible on the outputs after the rising edge ending cycle N (1-cycle latency).
- Per-register next-state priority, highest first:
  1. RESET
  2. CLR_AC (AC only)
  3. WRITE_EN bit
  4. INC/DEC
  5. hold
- Conflict cases:
  - WRITE_EN[0]=1 with INC_PC=1: PC loads BUS_C; the increment is dropped.
  - CLR_AC=1 with WRITE_EN[5]=1: AC becomes 0.
- Multiple WRITE_EN bits set: every selected register loads the same BUS_C value on that edge.
- Increment and decrement are modulo 2^WIDTH.
  - INC at 16'hFFFF gives 16'h0000.
  - DEC_R at 16'h0000 gives 16'hFFFF.
  - There is no carry or borrow output.
- Independent operations on different registers in the same cycle all take effect together (e.g. INC_PC, INC_AR, INC_R1, DEC_R and a WRITE_EN[2] load in one cycle).
- Flag timing:
  - Z_AC and Z_R are computed from the next-state values of AC and R, then registered.
  - Each flag therefore changes on the same edge as its register and never lags by a cycle.
- A register with no active enable holds its value indefinitely.
- X or undriven enables are illegal. The control unit guarantees all enables are 0 when idle.

Test Plan:
- Reset: RESET=1 for 1 cycle with PC_RESET=16'h0010 -> PC=16'h0010, R1..AR=0, Z_AC=1, Z_R=1; repeat with RESET asserted mid-increment burst -> same values.
- Loads: BUS_C=16'h1234 with WRITE_EN=7'b0100010 -> next cycle R1=AC=16'h1234, others unchanged, Z_AC=0; BUS_C=0, WRITE_EN[5]=1 -> AC=0, Z_AC=1 on the same edge.
- Wrap-around: PC=16'hFFFF, INC_PC=1 -> PC=16'h0000; R=16'h0000, DEC_R=1 -> R=16'hFFFF, Z_R=0; R=16'h0001, DEC_R=1 -> R=0, Z_R=1 on the same edge.
- Priority: WRITE_EN[0]=1, INC_PC=1, BUS_C=16'h00A0 -> PC=16'h00A0, not 16'h00A1; CLR_AC=1, WRITE_EN[5]=1, BUS_C=16'h5555 -> AC=0.
- Concurrency: INC_PC, INC_AR, INC_R1, DEC_R all =1 with WRITE_EN[3]=1, BUS_C=16'h0F0F from PC=AR=R1=1, R=3 -> PC=AR=R1=2, R=2, TR=16'h0F0F in one cycle.
- Hold: all enables 0 for 10 cycles after loading distinct values -> all outputs and flags stable.

Source files
------------

// File: rtl/register_bank.sv
// Datapath register file: PC, R1, R2, TR, R, AC, AR loaded from BUS_C or stepped in place,
// with registered zero flags for AC and R that track their registers edge-for-edge.
module register_bank #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   PC_RESET = 16'h0000
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [6:0]       WRITE_EN,
    input  logic             INC_PC,
    input  logic             INC_AR,
    input  logic             INC_R1,
    input  logic             DEC_R,
    input  logic             CLR_AC,
    input  logic [WIDTH-1:0] BUS_C,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] R1,
    output logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] TR,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] AC,
    output logic [WIDTH-1:0] AR,
    output logic             Z_AC,
    output logic             Z_R
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] pc_r, r1_r, r2_r, tr_r, r_r, ac_r, ar_r;
    logic [WIDTH-1:0] pc_s, r1_s, r2_s, tr_s, r_s, ac_s, ar_s;
    logic             z_ac_r, z_r_r;

    // Next-state selection per register: clear, then load, then step, then hold.
    always_comb begin
        pc_s = pc_r;
        r1_s = r1_r;
        r2_s = r2_r;
        tr_s = tr_r;
        r_s  = r_r;
        ac_s = ac_r;
        ar_s = ar_r;

        if (WRITE_EN[0]) begin
            pc_s = BUS_C;
        end else if (INC_PC) begin
            pc_s = pc_r + ONE;
        end else begin
            pc_s = pc_r;
        end

        if (WRITE_EN[1]) begin
            r1_s = BUS_C;
        end else if (INC_R1) begin
            r1_s = r1_r + ONE;
        end else begin
            r1_s = r1_r;
        end

        if (WRITE_EN[2]) begin
            r2_s = BUS_C;
        end else begin
            r2_s = r2_r;
        end

        if (WRITE_EN[3]) begin
            tr_s = BUS_C;
        end else begin
            tr_s = tr_r;
        end

        if (WRITE_EN[4]) begin
            r_s = BUS_C;
        end else if (DEC_R) begin
            r_s = r_r - ONE;
        end else begin
            r_s = r_r;
        end

        if (CLR_AC) begin
            ac_s = ZERO;
        end else if (WRITE_EN[5]) begin
            ac_s = BUS_C;
        end else begin
            ac_s = ac_r;
        end

        if (WRITE_EN[6]) begin
            ar_s = BUS_C;
        end else if (INC_AR) begin
            ar_s = ar_r + ONE;
        end else begin
            ar_s = ar_r;
        end
    end

    // State and flag registers; flags come from next-state so they never lag their register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_r   <= PC_RESET;
            r1_r   <= ZERO;
            r2_r   <= ZERO;
            tr_r   <= ZERO;
            r_r    <= ZERO;
            ac_r   <= ZERO;
            ar_r   <= ZERO;
            z_ac_r <= 1'b1;
            z_r_r  <= 1'b1;
        end else begin
            pc_r   <= pc_s;
            r1_r   <= r1_s;
            r2_r   <= r2_s;
            tr_r   <= tr_s;
            r_r    <= r_s;
            ac_r   <= ac_s;
            ar_r   <= ar_s;
            z_ac_r <= (ac_s == ZERO);
            z_r_r  <= (r_s == ZERO);
        end
    end

    assign PC   = pc_r;
    assign R1   = r1_r;
    assign R2   = r2_r;
    assign TR   = tr_r;
    assign R    = r_r;
    assign AC   = ac_r;
    assign AR   = ar_r;
    assign Z_AC = z_ac_r;
    assign Z_R  = z_r_r;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed vector table, multi-cycle corner sequences and random
// stimulus, all checked against an array-based model of the register rules.
module tb_register_bank;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [6:0]  WRITE_EN;
    logic        INC_PC, INC_AR, INC_R1, DEC_R, CLR_AC;
    logic [15:0] BUS_C;
    logic [15:0] PC, R1, R2, TR, R, AC, AR;
    logic        Z_AC, Z_R;

    int tests  = 0;
    int failed = 0;

    // index: 0 PC, 1 R1, 2 R2, 3 TR, 4 R, 5 AC, 6 AR
    logic [15:0] m [0:6];
    logic [15:0] snap [0:6];

    register_bank #(.WIDTH(16), .PC_RESET(16'h0010)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .WRITE_EN(WRITE_EN),
        .INC_PC(INC_PC), .INC_AR(INC_AR), .INC_R1(INC_R1), .DEC_R(DEC_R),
        .CLR_AC(CLR_AC), .BUS_C(BUS_C),
        .PC(PC), .R1(R1), .R2(R2), .TR(TR), .R(R), .AC(AC), .AR(AR),
        .Z_AC(Z_AC), .Z_R(Z_R)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [15:0] dut_reg(input int idx);
        case (idx)
            0: return PC;
            1: return R1;
            2: return R2;
            3: return TR;
            4: return R;
            5: return AC;
            6: return AR;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 7; i++) chk($sformatf("%s reg%0d", tag, i), dut_reg(i), m[i]);
        chk({tag, " Z_AC"}, {15'd0, Z_AC}, {15'd0, (m[5] == 16'd0)});
        chk({tag, " Z_R"},  {15'd0, Z_R},  {15'd0, (m[4] == 16'd0)});
    endtask

    // One clock: drive, step the model by the register rules, compare after the edge.
    task automatic cycle(input bit rst, input logic [6:0] we, input bit ipc, input bit iar,
                         input bit ir1, input bit dr, input bit clr, input logic [15:0] bus,
                         input string tag);
        RESET = rst; WRITE_EN = we; INC_PC = ipc; INC_AR = iar; INC_R1 = ir1;
        DEC_R = dr; CLR_AC = clr; BUS_C = bus;
        @(posedge CLOCK);
        #1;
        for (int i = 0; i < 7; i++) begin
            if (rst)                   m[i] = (i == 0) ? 16'h0010 : 16'h0000;
            else if (i == 5 && clr)    m[i] = 16'h0000;
            else if (we[i])            m[i] = bus;
            else if ((i == 0 && ipc) || (i == 1 && ir1) || (i == 6 && iar))
                                       m[i] = 16'((32'(m[i]) + 1) % 65536);
            else if (i == 4 && dr)     m[i] = 16'((32'(m[i]) + 65535) % 65536);
        end
        check_model(tag);
    endtask

    typedef struct {
        bit          rst;
        logic [6:0]  we;
        bit          ipc, iar, ir1, dr, clr;
        logic [15:0] bus;
        int          idx;
        logic [15:0] exp_val;
        bit          exp_zac, exp_zr;
    } vec_t;

    vec_t vt [14];

    initial begin
        RESET = 1'b1; WRITE_EN = 7'd0; INC_PC = 1'b0; INC_AR = 1'b0; INC_R1 = 1'b0;
        DEC_R = 1'b0; CLR_AC = 1'b0; BUS_C = 16'd0;
        for (int i = 0; i < 7; i++) m[i] = 16'd0;

        //          rst we          pc ar r1 dr clr bus       idx exp       zac zr
        vt[0]  = '{1'b1, 7'b0000000, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0010, 1, 1};
        vt[1]  = '{1'b0, 7'b0100010, 0, 0, 0, 0, 0, 16'h1234, 1, 16'h1234, 0, 1};
        vt[2]  = '{1'b0, 7'b0100000, 0, 0, 0, 0, 0, 16'h0000, 5, 16'h0000, 1, 1};
        vt[3]  = '{1'b0, 7'b0000001, 1, 0, 0, 0, 0, 16'h00A0, 0, 16'h00A0, 1, 1};
        vt[4]  = '{1'b0, 7'b0100000, 0, 0, 0, 0, 1, 16'h5555, 5, 16'h0000, 1, 1};
        vt[5]  = '{1'b0, 7'b0000001, 0, 0, 0, 0, 0, 16'hFFFF, 0, 16'hFFFF, 1, 1};
        vt[6]  = '{1'b0, 7'b0000000, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1};
        vt[7]  = '{1'b0, 7'b0000000, 0, 0, 0, 1, 0, 16'h0000, 4, 16'hFFFF, 1, 0};
        vt[8]  = '{1'b0, 7'b0010000, 0, 0, 0, 0, 0, 16'h0001, 4, 16'h0001, 1, 0};
        vt[9]  = '{1'b0, 7'b0000000, 0, 0, 0, 1, 0, 16'h0000, 4, 16'h0000, 1, 1};
        vt[10] = '{1'b0, 7'b1000011, 0, 0, 0, 0, 0, 16'h0001, 6, 16'h0001, 1, 1};
        vt[11] = '{1'b0, 7'b0010000, 0, 0, 0, 0, 0, 16'h0003, 4, 16'h0003, 1, 0};
        vt[12] = '{1'b0, 7'b0001000, 1, 1, 1, 1, 0, 16'h0F0F, 3, 16'h0F0F, 1, 0};
        vt[13] = '{1'b0, 7'b0100000, 0, 0, 0, 0, 0, 16'h8000, 5, 16'h8000, 0, 0};

        @(negedge CLOCK);
        for (int v = 0; v < 14; v++) begin
            cycle(vt[v].rst, vt[v].we, vt[v].ipc, vt[v].iar, vt[v].ir1, vt[v].dr, vt[v].clr,
                  vt[v].bus, $sformatf("vec%0d model", v));
            chk($sformatf("vec%0d reg%0d", v, vt[v].idx), dut_reg(vt[v].idx), vt[v].exp_val);
            chk($sformatf("vec%0d Z_AC", v), {15'd0, Z_AC}, {15'd0, vt[v].exp_zac});
            chk($sformatf("vec%0d Z_R", v),  {15'd0, Z_R},  {15'd0, vt[v].exp_zr});
        end
        // concurrency vector started from PC=AR=R1=1, R=3
        chk("concurrent PC", PC, 16'h0002);
        chk("concurrent AR", AR, 16'h0002);
        chk("concurrent R1", R1, 16'h0002);
        chk("concurrent R",  R,  16'h0002);

        // Hold: distinct values, then ten idle cycles must not disturb anything.
        cycle(1'b0, 7'b0000100, 0, 0, 0, 0, 0, 16'hBEEF, "hold load");
        for (int i = 0; i < 7; i++) snap[i] = m[i];
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 7'd0, 0, 0, 0, 0, 0, 16'hA5A5, $sformatf("hold%0d", c));
            for (int i = 0; i < 7; i++) chk($sformatf("hold%0d reg%0d", c, i), dut_reg(i), snap[i]);
        end

        // Reset landing in the middle of an increment/load burst.
        for (int c = 0; c < 3; c++) cycle(1'b0, 7'd0, 1, 1, 1, 1, 0, 16'h0000, "burst");
        cycle(1'b1, 7'b1111111, 1, 1, 1, 1, 1, 16'h7777, "burst reset");
        chk("midreset PC", PC, 16'h0010);
        chk("midreset AC", AC, 16'h0000);
        chk("midreset R",  R,  16'h0000);
        chk("midreset Z_AC", {15'd0, Z_AC}, 16'd1);
        chk("midreset Z_R",  {15'd0, Z_R},  16'd1);

        // Random traffic against the model; bus biased toward 0/1/FFFF to exercise flags and wraps.
        for (int c = 0; c < 400; c++) begin
            logic [15:0] bus;
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: bus = 16'h0000;
                1: bus = 16'h0001;
                2: bus = 16'hFFFF;
                default: bus = 16'($urandom);
            endcase
            cycle(($urandom_range(0, 31) == 0), 7'($urandom & $urandom & $urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0), bus, $sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
